// File: rtl/uart_rx_if.sv
// uart_rx_if: receiver output bundle; master = uart_rx (drives byte, valid, busy, frame_err, tick_debug), slave = downstream consumer
interface uart_rx_if;
  logic [7:0] o_rx_data;
  logic       o_rx_valid;
  logic       o_rx_busy;
  logic       o_frame_err;
  logic       o_tick_debug;
  modport master (output o_rx_data, o_rx_valid, o_rx_busy, o_frame_err, o_tick_debug);
  modport slave  (input  o_rx_data, o_rx_valid, o_rx_busy, o_frame_err, o_tick_debug);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver; i_clk, rst (async active-low), i_rx_serial in; byte/valid/busy/frame_err/tick_debug out via uart_rx_if.master
module uart_rx #(
  parameter int TICK_FULL = 837,
  parameter int TICK_HALF = 419
) (
  input  logic     i_clk,
  input  logic     rst,
  input  logic     i_rx_serial,
  uart_rx_if.master bus
);
  localparam int CW = $clog2(TICK_FULL + 1);
  localparam logic [CW-1:0] FULL = CW'(TICK_FULL);
  localparam logic [CW-1:0] HALF = CW'(TICK_HALF);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3, BRK = 3'd4;
  logic          s1_q, rx_s_q, prev_q, fall;
  logic [2:0]    state_q, state_d, idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    sh_q, sh_d, data_q, data_d;
  logic          valid_q, valid_d, err_q, err_d, tick_q, tick_d, busy_q, busy_d;
  assign fall = prev_q & ~rx_s_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    tick_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        busy_d  = fall;
        state_d = fall ? START : IDLE;
      end
      START: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == HALF) begin
          tick_d  = 1'b1;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
          busy_d  = ~rx_s_q;
        end
      end
      DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == FULL) begin
          tick_d      = 1'b1;
          cnt_d       = '0;
          sh_d[idx_q] = rx_s_q;
          idx_d       = idx_q + 1'b1;
          state_d     = (idx_q == 3'd7) ? STOP : DATA;
        end
      end
      STOP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == FULL) begin
          tick_d  = 1'b1;
          cnt_d   = '0;
          valid_d = rx_s_q;
          err_d   = ~rx_s_q;
          data_d  = rx_s_q ? sh_q : data_q;
          busy_d  = ~rx_s_q;
          state_d = rx_s_q ? IDLE : BRK;
        end
      end
      BRK: begin
        busy_d  = ~rx_s_q;
        state_d = rx_s_q ? IDLE : BRK;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end
  always_ff @(posedge i_clk or negedge rst) begin
    if (!rst) begin
      s1_q    <= 1'b1;
      rx_s_q  <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      s1_q    <= i_rx_serial;
      rx_s_q  <= s1_q;
      prev_q  <= rx_s_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
    end
  end
  assign bus.o_rx_data    = data_q;
  assign bus.o_rx_valid   = valid_q;
  assign bus.o_rx_busy    = busy_q;
  assign bus.o_frame_err  = err_q;
  assign bus.o_tick_debug = tick_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed checks of uart_rx against a frame-level reference model
module tb_uart_rx;
  localparam int BL = 16;
  localparam int BD = 838;
  localparam int LAT_F = 2 + 1 + 8 + 9 * 16 + 1;
  localparam int LAT_D = 2 + 1 + 420 + 9 * 838 + 1;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b0, rx = 1'b1, rx_d = 1'b1;
  uart_rx_if bf();
  uart_rx_if bd();
  uart_rx #(.TICK_FULL(15), .TICK_HALF(7)) dut (.i_clk(clk), .rst(rst), .i_rx_serial(rx), .bus(bf));
  uart_rx dutd (.i_clk(clk), .rst(rst), .i_rx_serial(rx_d), .bus(bd));
  int errs = 0, checks = 0, cyc = 0, tfall = 0;
  int nval = 0, nerr = 0, ntick = 0, nbusy = 0, novl = 0, brise = 0;
  int nval_d = 0, nerr_d = 0, ntick_d = 0;
  logic pbusy = 1'b0;
  logic [7:0] gotd [64];
  int valt [64];
  logic [7:0] gotd_d [4];
  int valt_d [4];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bf.o_rx_valid) begin
      gotd[nval[5:0]] <= bf.o_rx_data;
      valt[nval[5:0]] <= cyc;
      nval <= nval + 1;
    end
    if (bd.o_rx_valid) begin
      gotd_d[nval_d[1:0]] <= bd.o_rx_data;
      valt_d[nval_d[1:0]] <= cyc;
      nval_d <= nval_d + 1;
    end
    if (bf.o_rx_busy && !pbusy) brise <= cyc;
    pbusy   <= bf.o_rx_busy;
    nerr    <= nerr + int'(bf.o_frame_err);
    ntick   <= ntick + int'(bf.o_tick_debug);
    nbusy   <= nbusy + int'(bf.o_rx_busy);
    novl    <= novl + int'(bf.o_rx_valid & bf.o_frame_err) + int'(bd.o_rx_valid & bd.o_frame_err);
    nerr_d  <= nerr_d + int'(bd.o_frame_err);
    ntick_d <= ntick_d + int'(bd.o_tick_debug);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic setl(input bit sel, input logic v);
    if (sel) rx_d = v;
    else rx = v;
  endtask
  task automatic send(input logic [7:0] b, input logic stop, input bit sel);
    int bl = sel ? BD : BL;
    setl(sel, 1'b0);
    tfall = cyc;
    idle(bl);
    for (int i = 0; i < 8; i++) begin
      setl(sel, b[i]);
      idle(bl);
    end
    setl(sel, stop);
    idle(bl);
  endtask
  task automatic check_rst(input string tag);
    check({tag, "_data"}, bf.o_rx_data, 8'h00);
    check({tag, "_valid"}, bf.o_rx_valid, 0);
    check({tag, "_busy"}, bf.o_rx_busy, 0);
    check({tag, "_err"}, bf.o_frame_err, 0);
    check({tag, "_tick"}, bf.o_tick_debug, 0);
  endtask
  initial begin
    int v0, t0, e0, b0, d, experr;
    int tf [3];
    logic [7:0] t6b [3];
    logic [7:0] exp_q [$];
    logic [7:0] lastgood, rb;
    logic st;
    t6b = '{8'h5A, 8'h01, 8'h80};
    idle(3);
    check_rst("rst");
    check("rst_d_data", bd.o_rx_data, 8'h00);
    rst = 1'b1;
    idle(4);
    v0 = nval; t0 = ntick; e0 = nerr;
    send(8'hA5, 1'b1, 1'b0);
    idle(BL);
    check("t1_nval", nval - v0, 1);
    check("t1_data", gotd[v0], 8'hA5);
    check("t1_ticks", ntick - t0, 10);
    check("t1_err", nerr - e0, 0);
    d = valt[v0] - tfall;
    check("t1_lat_ok", (d >= LAT_F - 1 && d <= LAT_F + 1), 1);
    v0 = nval; t0 = ntick; e0 = nerr; b0 = nbusy;
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(3 * BL);
    check("t2_nval", nval - v0, 0);
    check("t2_err", nerr - e0, 0);
    check("t2_ticks", ntick - t0, 1);
    check("t2_busy_cyc", nbusy - b0, 8);
    check("t2_busy_now", bf.o_rx_busy, 0);
    v0 = nval; t0 = ntick; e0 = nerr;
    send(8'h3C, 1'b1, 1'b0);
    idle(2 * BL);
    send(8'h7E, 1'b0, 1'b0);
    idle(100);
    check("t3_busy_brk", bf.o_rx_busy, 1);
    check("t3_err", nerr - e0, 1);
    check("t3_ticks", ntick - t0, 20);
    rx = 1'b1;
    idle(4);
    check("t3_busy_rel", bf.o_rx_busy, 0);
    check("t3_nval", nval - v0, 1);
    check("t3_data_q", gotd[v0], 8'h3C);
    check("t3_data_hold", bf.o_rx_data, 8'h3C);
    check("t3_err_once", nerr - e0, 1);
    idle(BL);
    v0 = nval;
    send(8'h00, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b0);
    idle(BL);
    check("t4_nval", nval - v0, 2);
    check("t4_data0", gotd[v0], 8'h00);
    check("t4_data1", gotd[v0 + 1], 8'hFF);
    d = brise - tfall;
    check("t4_detect_ok", (d >= 0 && d <= 3), 1);
    v0 = nval; e0 = nerr;
    fork
      send(8'h55, 1'b1, 1'b0);
      begin
        idle(BL + 4 * BL + BL / 2);
        rst = 1'b0;
        idle(2);
        check_rst("t5_rst");
      end
    join
    idle(2);
    rst = 1'b1;
    idle(2 * BL);
    check("t5_abort_nval", nval - v0, 0);
    check("t5_abort_err", nerr - e0, 0);
    send(8'hC3, 1'b1, 1'b0);
    idle(BL);
    check("t5_nval", nval - v0, 1);
    check("t5_data", gotd[v0], 8'hC3);
    v0 = nval_d; t0 = ntick_d;
    for (int k = 0; k < 3; k++) begin
      send(t6b[k], 1'b1, 1'b1);
      tf[k] = tfall;
      idle(BD);
    end
    idle(BD);
    check("t6_nval", nval_d - v0, 3);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t6_data%0d", k), gotd_d[(v0 + k) % 4], t6b[k]);
      d = valt_d[(v0 + k) % 4] - tf[k];
      check($sformatf("t6_lat%0d_ok", k), (d >= LAT_D - 1 && d <= LAT_D + 1), 1);
    end
    check("t6_ticks", ntick_d - t0, 30);
    check("t6_err", nerr_d, 0);
    check("t6_busy", bd.o_rx_busy, 0);
    v0 = nval; e0 = nerr; experr = 0;
    lastgood = bf.o_rx_data;
    for (int k = 0; k < 16; k++) begin
      rb = 8'($urandom_range(0, 255));
      st = ($urandom_range(0, 5) != 0);
      send(rb, st, 1'b0);
      rx = 1'b1;
      idle($urandom_range(1, 3) * BL);
      if (st) begin
        exp_q.push_back(rb);
        lastgood = rb;
      end else experr++;
    end
    idle(BL);
    check("rnd_nval", nval - v0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) check($sformatf("rnd_data%0d", i), gotd[v0 + i], exp_q[i]);
    check("rnd_err", nerr - e0, experr);
    check("rnd_last", bf.o_rx_data, lastgood);
    check("valid_err_overlap", novl, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
8N1 UART receiver, the receive-side counterpart of the team's UART transmitter. It shares the same bit timing: one bit lasts TICK_FULL+1 i_clk cycles, which is 838 at the defaults. The block synchronises the asynchronous serial line, detects and validates the start bit, and samples 8 data bits LSB-first at mid-bit. It checks the stop bit and presents the byte with a one-cycle valid pulse to downstream logic (FIFO or command parser).

Parameters:
TICK_FULL, 837, bit period minus 1 in i_clk cycles; must match the transmitter.
TICK_HALF, 419, count at which the start bit is re-sampled after the falling edge; must be < TICK_FULL.

Ports:
i_clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
i_rx_serial  in  1  asynchronous serial line, idle high
o_rx_data  out  8  last correctly framed byte; holds until the next good frame
o_rx_valid  out  1  one-cycle pulse: o_rx_data updated this cycle
o_rx_busy  out  1  high from start-edge detection until return to IDLE
o_frame_err  out  1  one-cycle pulse: stop bit sampled low
o_tick_debug  out  1  one-cycle pulse at every sample point (start check, each data bit, stop)

Behaviour:
- Reset (rst=0, asynchronous, active-low):
  - state=IDLE, bit counter=0, tick counter=0, shift register=0.
  - o_rx_data=8'h00; o_rx_valid, o_rx_busy, o_frame_err and o_tick_debug all 0.
  - Both synchroniser flops preset to 1, so reset never produces a false start.
- Input path: 2-flop synchroniser, followed by a registered copy used for falling-edge detection. The FSM acts only on the synchronised signal (rx_s).
- IDLE:
  - busy=0, count=0.
  - On rx_s falling edge (prev=1, cur=0) go to START_CHECK and set busy=1 in the same transition.
- START_CHECK:
  - Count increments each cycle.
  - At count==TICK_HALF, pulse tick_debug and sample rx_s.
  - Sample 0: go to DATA with count=0, bit index=0.
  - Sample 1: glitch; return to IDLE with no valid/err pulse.
- DATA:
  - Count increments to TICK_FULL, then resets to 0.
  - At count==TICK_FULL, pulse tick_debug and write rx_s into shift bit [index] (LSB first), then index+1.
  - After the bit with index 7 is captured, go to STOP with count=0.
- STOP:
  - At count==TICK_FULL, pulse tick_debug and sample rx_s.
  - Sample 1: load o_rx_data from the shift register and pulse o_rx_valid for one cycle (registered, in the cycle after the sample edge). Go to IDLE.
  - Sample 0: pulse o_frame_err for one cycle and leave o_rx_data unchanged. Go to BREAK_WAIT.
- BREAK_WAIT:
  - busy stays 1.
  - Remain until rx_s==1, then go to IDLE. A held-low line (break) therefore yields exactly one frame_err, not repeated frames.
- Illegal or unused state encoding: go to IDLE with all pulses 0.
- o_rx_valid and o_frame_err are never high in the same cycle. Each occurs at most once per frame.
- Back-to-back frames: IDLE is re-entered at the mid-stop sample, so a start edge arriving half a bit later is caught. No minimum idle time is required beyond the stop half-bit.
- Latency: line falling edge to o_rx_valid = 2 (sync) + 1 (edge) + (TICK_HALF+1) + 9×(TICK_FULL+1) + 1 cycles, ±1 for edge phase.
- Reset mid-frame: immediate return to IDLE, outputs to reset values, and the partial byte is discarded.
- Counters are sized with $clog2(TICK_FULL+1) bits. There is no wrap-around, because every counter is cleared at its terminal value.

Test Plan:
1. TICK_FULL=15, TICK_HALF=7; drive byte 8'hA5 in 8N1 at 16 clk/bit → exactly one o_rx_valid pulse with o_rx_data=8'hA5, 10 tick_debug pulses, o_frame_err never 1.
2. Same params; 3-cycle low glitch on idle line → state returns to IDLE after the START_CHECK sample; no valid/err pulse; busy high for ≈TICK_HALF+1 cycles only.
3. Send 8'h3C, then 8'h7E with stop bit forced 0 → valid for 8'h3C; for the second frame, a single frame_err pulse and o_rx_data still 8'h3C. Hold line low 100 cycles → no further pulses; busy falls only after the line returns high.
4. Back-to-back 8'h00 then 8'hFF with zero extra idle → two valid pulses, data 8'h00 then 8'hFF; the second start is detected within 3 cycles of the falling edge.
5. Assert rst low during data bit 4 of 8'h55, release, then send 8'hC3 → no pulse for the aborted frame; all outputs 0 during reset; 8'hC3 received correctly.
6. Default params, looped back from the team's UART transmitter sending 8'h5A, 8'h01, 8'h80 → three valid pulses with matching data; each valid lands within ±1 cycle of the computed latency.
